// File: rtl/pipeline_stall_controller_if.sv
// Purpose : hazard-request / stall-vector bundle between pipeline stages and the stall controller.
// Latency : plain wires, no state.
// Backpressure: none; the stall vector itself is the backpressure into the pipeline buffers.
// Ports   : requests (id/ex/mem/flush) flow into the controller, stall/status flow out.
interface pipeline_stall_controller_if #(
    parameter int STALL_WIDTH = 6,
    parameter int CNT_WIDTH   = 6
);
    logic                   id_stall_request;
    logic                   ex_multicycle_start;
    logic [CNT_WIDTH-1:0]   ex_multicycle_cycles;
    logic                   ex_multicycle_cancel;
    logic                   mem_stall_request;
    logic                   flush;
    logic [STALL_WIDTH-1:0] stall;
    logic                   ex_busy;
    logic                   ex_done;
    logic                   mem_timeout;
    logic [31:0]            stall_cycles;

    // Pipeline side: raises requests, consumes the stall vector and status.
    modport master (
        output id_stall_request, ex_multicycle_start, ex_multicycle_cycles,
               ex_multicycle_cancel, mem_stall_request, flush,
        input  stall, ex_busy, ex_done, mem_timeout, stall_cycles
    );

    // Controller side.
    modport slave (
        input  id_stall_request, ex_multicycle_start, ex_multicycle_cycles,
               ex_multicycle_cancel, mem_stall_request, flush,
        output stall, ex_busy, ex_done, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Purpose : central stall sequencer: priority-merges ID/EX/MEM stalls, runs the EX multi-cycle FSM,
//           MEM wait watchdog and stall performance counter.
// Latency : stall vector is combinational from requests and FSM state (zero-cycle hold on start).
// Backpressure: stall bits hold pc..mem buffers; a MEM stall freezes a finished EX result in DONE.
// Ports   : clock, reset (sync, active-low), bus (slave modport of pipeline_stall_controller_if).
module pipeline_stall_controller #(
    parameter int STALL_WIDTH = 6,
    parameter int CNT_WIDTH   = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    pipeline_stall_controller_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Stall masks: bit0=PC .. bit5=WB. Each source holds its own stage and everything upstream.
    localparam logic [STALL_WIDTH-1:0] MASK_MEM = STALL_WIDTH'(5'h1F);
    localparam logic [STALL_WIDTH-1:0] MASK_EX  = STALL_WIDTH'(4'hF);
    localparam logic [STALL_WIDTH-1:0] MASK_ID  = STALL_WIDTH'(3'h7);
    localparam logic [15:0]            WD_LIMIT = 16'(MEM_TIMEOUT);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [15:0]            wd_q, wd_d;
    logic                   timeout_q;
    logic [31:0]            stall_cycles_q;

    logic                   abort;
    logic                   start_ok;
    logic                   ex_stall;
    logic [STALL_WIDTH-1:0] stall_raw;

    assign abort    = bus.flush | bus.ex_multicycle_cancel;
    assign start_ok = (state_q == S_IDLE) && bus.ex_multicycle_start &&
                      (bus.ex_multicycle_cycles != '0) && !abort;
    // The start cycle itself already stalls so id/ex holds the operands.
    assign ex_stall = (state_q == S_BUSY) || start_ok;

    always_comb begin
        stall_raw = '0;
        if (bus.flush)                 stall_raw = '0;
        else if (bus.mem_stall_request) stall_raw = MASK_MEM;
        else if (ex_stall)             stall_raw = MASK_EX;
        else if (bus.id_stall_request) stall_raw = MASK_ID;
    end

    // Countdown holds the stall cycles still owed after the current one; BUSY leaves
    // for DONE on the cycle it would reach zero. N=1 owes nothing and goes straight to DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        cnt_d   = bus.ex_multicycle_cycles - CNT_WIDTH'(1);
                        state_d = (bus.ex_multicycle_cycles == CNT_WIDTH'(1)) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Keeps counting through MEM stalls; start requests are ignored here.
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) state_d = S_DONE;
                end
                S_DONE: begin
                    cnt_d = '0;
                    // Hold the result while MEM is stalled so EX does not miss it.
                    if (!bus.mem_stall_request) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        wd_d = wd_q;
        if (bus.flush || !bus.mem_stall_request) wd_d = '0;
        else if (wd_q != WD_LIMIT)               wd_d = wd_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wd_q           <= '0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wd_q           <= wd_d;
            if (wd_d == WD_LIMIT) timeout_q <= 1'b1;
            stall_cycles_q <= stall_cycles_q + 32'(stall_raw[0]);
        end
    end

    assign bus.stall        = reset ? stall_raw : '0;
    assign bus.ex_busy      = reset && (state_q == S_BUSY);
    // A result in DONE is discarded if the same cycle is flushed or cancelled.
    assign bus.ex_done      = reset && (state_q == S_DONE) && !abort;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Purpose : self-checking bench for pipeline_stall_controller (scoreboard + behavioural model).
// Latency : expected outputs for a cycle are queued at drive time and checked at the next negedge.
// Backpressure: n/a.
module tb_pipeline_stall_controller;
    localparam int MEM_TO = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipeline_stall_controller_if #(.STALL_WIDTH(6), .CNT_WIDTH(6)) bus ();

    pipeline_stall_controller #(
        .STALL_WIDTH(6), .CNT_WIDTH(6), .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        busy;
        logic        done;
        logic        to;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model state: stall cycles of the EX op still to come, a pending result,
    // consecutive MEM-stall run length, sticky timeout, stall counter.
    int          m_left = 0;
    bit          m_done = 0;
    int          m_wd   = 0;
    bit          m_to   = 0;
    logic [31:0] m_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle is an output beat; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",        32'(bus.stall),      32'(e.stall));
                chk("ex_busy",      32'(bus.ex_busy),    32'(e.busy));
                chk("ex_done",      32'(bus.ex_done),    32'(e.done));
                chk("mem_timeout",  32'(bus.mem_timeout), 32'(e.to));
                chk("stall_cycles", bus.stall_cycles,    e.cnt);
            end
        end
    end

    task automatic drive(input logic r, input logic id, input logic st, input logic [5:0] n,
                         input logic cn, input logic mem, input logic fl);
        exp_t e;
        bit   abort, start_ok, ex_st;
        @(posedge clock);
        #1;
        reset                    = r;
        bus.id_stall_request     = id;
        bus.ex_multicycle_start  = st;
        bus.ex_multicycle_cycles = n;
        bus.ex_multicycle_cancel = cn;
        bus.mem_stall_request    = mem;
        bus.flush                = fl;
        if (!r) begin
            e.stall = 6'h00; e.busy = 0; e.done = 0; e.to = m_to; e.cnt = m_cnt;
            q.push_back(e);
            m_left = 0; m_done = 0; m_wd = 0; m_to = 0; m_cnt = 0;
            return;
        end
        abort    = fl || cn;
        start_ok = (m_left == 0) && !m_done && st && (n != 0) && !abort;
        ex_st    = (m_left > 0) || start_ok;
        e.stall  = fl ? 6'h00 : mem ? 6'h1F : ex_st ? 6'h0F : id ? 6'h07 : 6'h00;
        e.busy   = (m_left > 0);
        e.done   = m_done && !abort;
        e.to     = m_to;
        e.cnt    = m_cnt;
        q.push_back(e);
        // Advance the model to the next cycle.
        if (abort) begin
            m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (m_done) begin
            m_done = mem;
        end else if (start_ok) begin
            m_left = int'(n) - 1;
            m_done = (n == 1);
        end
        if (fl || !mem)       m_wd = 0;
        else if (m_wd < MEM_TO) m_wd++;
        if (m_wd == MEM_TO) m_to = 1;
        m_cnt = m_cnt + 32'(e.stall[0]);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 0;
        bus.id_stall_request = 0; bus.ex_multicycle_start = 0; bus.ex_multicycle_cycles = 0;
        bus.ex_multicycle_cancel = 0; bus.mem_stall_request = 0; bus.flush = 0;
        repeat (2) @(posedge clock);

        // Reset held with every request active.
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 6'd4, 1, 1, 1);

        // N=4 multi-cycle op on an otherwise quiet pipeline.
        idle(6);
        drive(1, 0, 1, 6'd4, 0, 0, 0);
        idle(6);

        // N=1: single stall cycle then done.
        drive(1, 0, 1, 6'd1, 0, 0, 0);
        idle(3);

        // N=3 with MEM stall (and ID) over cycles 1..5: DONE held while MEM stalls.
        drive(1, 0, 1, 6'd3, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 6'd5, 0, 1, 0);
        idle(3);

        // N=10 flushed on the third BUSY cycle; then N=0 is ignored.
        drive(1, 0, 1, 6'd10, 0, 0, 0);
        idle(2);
        drive(1, 1, 0, 0, 0, 1, 1);
        idle(12);
        drive(1, 0, 1, 6'd0, 0, 0, 0);
        idle(3);

        // Cancel mid-op, and start ignored while busy.
        drive(1, 0, 1, 6'd6, 0, 0, 0);
        drive(1, 0, 1, 6'd2, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        idle(8);

        // Watchdog: 7 cycles short, gap, 8 cycles trips; sticky until reset.
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0, 1, 0);
        idle(4);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Counter wrap: preload all-ones, then one stall cycle.
        @(posedge clock);
        #1;
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        drive(1, 0, 0, 0, 0, 0, 0);
        release dut.stall_cycles_q;
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] n;
            n = 6'($urandom_range(0, 12));
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  n,
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 39) == 0));
        end
        idle(2);

        @(negedge clock);
        #1;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall sequencer for the 5-stage pipeline. It collects stall requests from ID (load-use), EX (multi-cycle ops such as div) and MEM (memory not ready) and drives the shared stall vector consumed by pc, if/id, id/ex, ex/mem and mem/wb buffers. It owns the EX multi-cycle countdown FSM, a MEM wait-timeout watchdog and a stall performance counter.

Parameters:
STALL_WIDTH, 6, stall vector width; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
CNT_WIDTH, 6, width of EX multi-cycle count
MEM_TIMEOUT, 255, consecutive MEM-stall cycles before mem_timeout is raised (1..2^16-1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
id_stall_request  in  1  load-use hazard in ID, valid same cycle
ex_multicycle_start  in  1  EX begins multi-cycle op (single-cycle pulse)
ex_multicycle_cycles  in  CNT_WIDTH  op length N, sampled with start
ex_multicycle_cancel  in  1  abort in-flight multi-cycle op
mem_stall_request  in  1  memory access not complete
flush  in  1  exception/redirect flush
stall  out  STALL_WIDTH  stall vector (combinational)
ex_busy  out  1  FSM in BUSY
ex_done  out  1  multi-cycle result ready for EX to forward
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  32  count of cycles with stall[0]=1

Behaviour:
- Reset (reset=0 at rising edge): FSM=IDLE, countdown=0, watchdog count=0, mem_timeout=0, stall_cycles=0. While reset=0, stall forced to 0, ex_busy=0, ex_done=0.
- Stall vector, priority flush > MEM > EX > ID:
  flush=1 -> 000000; mem_stall_request=1 -> 011111; ex_stall -> 001111; id_stall_request=1 -> 000111; else 000000.
- ex_stall = (state==BUSY) or (state==IDLE and ex_multicycle_start and N!=0 and not flush and not cancel); zero-latency so id/ex buffer holds on the start cycle.
- FSM states IDLE, BUSY, DONE:
  IDLE: start with N!=0 (no flush/cancel) -> BUSY, countdown=N-1. N=0 ignored, stays IDLE, no stall.
  BUSY: countdown decrements every cycle, also during MEM stall; countdown==0 -> DONE. Start while BUSY ignored.
  DONE: ex_done=1, no EX stall; -> IDLE when mem_stall_request=0, else hold DONE (ex_done stays 1) so result is not lost.
  flush or ex_multicycle_cancel in any state -> IDLE next edge, no ex_done.
- Net: start at cycle t with N -> EX stall cycles t..t+N-1, ex_done=1 at cycle t+N (absent MEM stall); N=1 gives one stall cycle.
- ex_busy = (state==BUSY).
- Watchdog: counter increments each cycle mem_stall_request=1, clears when 0 or on flush; saturates at MEM_TIMEOUT; reaching MEM_TIMEOUT sets mem_timeout, which stays 1 until reset. Flag does not alter stall.
- stall_cycles: +1 each edge where stall[0]=1; wraps 0xFFFFFFFF -> 0.
- Reset mid-BUSY: all state cleared that edge; no ex_done afterwards.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all requests=1 -> stall=0, ex_busy=0, ex_done=0, mem_timeout=0, stall_cycles=0.
- Multi-cycle: start with N=4 at cycle 10 -> stall=001111 cycles 10..13, ex_busy=1 cycles 11..13, ex_done=1 cycle 14 only, stall_cycles=4.
- Priority: id_stall_request=1 and mem_stall_request=1 during BUSY -> stall=011111; countdown continues; N=3 start at cycle 0 with MEM stall cycles 1..5 -> DONE from cycle 3, ex_done held through cycle 5, IDLE at 6.
- Cancel/flush: N=10 start, flush at 3rd BUSY cycle -> stall=000000 that cycle, IDLE next, ex_done never asserts; start with N=0 -> no stall, no ex_done.
- Watchdog: MEM_TIMEOUT=8, mem_stall_request=1 for 7 cycles -> mem_timeout=0; then drop 1 cycle, reassert 8 cycles -> mem_timeout=1 and stays 1 after deassert until reset=0.
- Counter wrap: preload via 2^32-1 stall cycles (or force) then one more stall -> stall_cycles=0.
